// File: rtl/trigger_gate.sv
// Threshold trigger and frame gating stage fed by the baseline calculator.
// Optional feature: define TRIG_TIMESTAMP_EN for a 48-bit cycle timestamp of each trigger.
module trigger_gate #(
  parameter int THRESHOLD            = 410,
  parameter int ADC_RESOLUTION_WIDTH = 12,
  parameter int S_AXIS_TDATA_WIDTH   = 128,
  parameter int PRE_ACQ_LEN          = 2,
  parameter int POST_ACQ_LEN         = 4,
  parameter int MAX_TRIGGER_LEN      = 64
) (
  input  logic                            AXIS_ACLK,
  input  logic                            AXIS_ARESETN,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] I_BASELINE,
  input  logic                            I_CALC_COMPLETE,
  input  logic [S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic                            S_AXIS_TVALID,
  output logic [S_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic                            M_AXIS_TVALID,
  output logic                            M_AXIS_TLAST,
  output logic [1:0]                      O_EXEC_STATE,
  output logic [31:0]                     O_TRIG_CNT,
  output logic [47:0]                     O_TRIG_TIMESTAMP
);

  localparam int NSAMP      = S_AXIS_TDATA_WIDTH / 16;
  localparam int SW         = ADC_RESOLUTION_WIDTH + 1;
  localparam int CAP        = MAX_TRIGGER_LEN - PRE_ACQ_LEN;
  localparam int WIN_W      = $clog2(MAX_TRIGGER_LEN + 1);
  localparam int POST_W     = $clog2(POST_ACQ_LEN + 1);
  localparam int TAIL_W     = $clog2(PRE_ACQ_LEN + 2);
  localparam bit CLOSE_AT_T = (CAP <= 1);
  localparam bit NO_PRE     = (PRE_ACQ_LEN == 0);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_ARMED = 2'b01,
    ST_TRG   = 2'b11,
    ST_POST  = 2'b10
  } state_t;

  state_t                          r_state, w_state_next;
  logic [WIN_W-1:0]                r_win, w_win_next, w_win_inc;
  logic [POST_W-1:0]               r_post, w_post_next, w_post_inc;
  logic [TAIL_W-1:0]               r_tail, w_tail_next;
  logic                            w_gate, w_close, w_trig, w_last;
  logic [S_AXIS_TDATA_WIDTH-1:0]   r_m_data;
  logic                            r_m_valid, r_m_last;
  logic [31:0]                     r_trig_cnt;
  logic [S_AXIS_TDATA_WIDTH-1:0]   w_dly_out;

  // Unsaturated ADC_RESOLUTION_WIDTH+1 sum: a level above full scale can never be exceeded.
  logic [SW-1:0]    w_level;
  logic [NSAMP-1:0] w_samp_hit;
  logic             w_hit;

  assign w_level = {1'b0, I_BASELINE} + SW'(THRESHOLD);

  for (genvar gi = 0; gi < NSAMP; gi++) begin : g_cmp
    assign w_samp_hit[gi] = {1'b0, S_AXIS_TDATA[16*gi +: ADC_RESOLUTION_WIDTH]} > w_level;
  end
  assign w_hit = |w_samp_hit;

  if (NO_PRE) begin : g_nodly
    assign w_dly_out = S_AXIS_TDATA;
  end else begin : g_dly
    logic [S_AXIS_TDATA_WIDTH-1:0] r_dly [PRE_ACQ_LEN];
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
        for (int i = 0; i < PRE_ACQ_LEN; i++) r_dly[i] <= '0;
      end else if (S_AXIS_TVALID) begin
        r_dly[0] <= S_AXIS_TDATA;
        for (int i = 1; i < PRE_ACQ_LEN; i++) r_dly[i] <= r_dly[i-1];
      end
    end
    assign w_dly_out = r_dly[PRE_ACQ_LEN-1];
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      r_state <= ST_INIT;
      r_win   <= '0;
      r_post  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_next;
      r_win   <= w_win_next;
      r_post  <= w_post_next;
      r_tail  <= w_tail_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_win_next   = r_win;
    w_post_next  = r_post;
    w_tail_next  = r_tail;
    w_gate       = 1'b0;
    w_close      = 1'b0;
    w_trig       = 1'b0;
    w_win_inc    = r_win + WIN_W'(1);
    w_post_inc   = (r_state == ST_TRG) ? POST_W'(1) : r_post + POST_W'(1);
    case (r_state)
      ST_INIT: begin
        if (I_CALC_COMPLETE) w_state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (S_AXIS_TVALID) begin
          // Tail beats flush the delay line; new hits wait so frames never overlap.
          if (r_tail != '0) begin
            w_tail_next = r_tail - TAIL_W'(1);
            w_gate      = 1'b1;
          end else if (w_hit) begin
            w_gate       = 1'b1;
            w_trig       = 1'b1;
            w_win_next   = WIN_W'(1);
            w_post_next  = '0;
            w_state_next = ST_TRG;
            if (CLOSE_AT_T) w_close = 1'b1;
          end
        end
      end
      default: begin
        if (S_AXIS_TVALID) begin
          w_gate     = 1'b1;
          w_win_next = w_win_inc;
          if (w_hit) begin
            w_state_next = ST_TRG;
            w_post_next  = '0;
          end else begin
            w_state_next = ST_POST;
            w_post_next  = w_post_inc;
            if (w_post_inc >= POST_W'(POST_ACQ_LEN)) w_close = 1'b1;
          end
          if (w_win_inc >= WIN_W'(CAP)) w_close = 1'b1;
        end
      end
    endcase
    if (w_close) begin
      w_state_next = ST_ARMED;
      w_tail_next  = TAIL_W'(PRE_ACQ_LEN);
    end
  end

  assign w_last = NO_PRE ? w_close
                         : (r_state == ST_ARMED) && S_AXIS_TVALID && (r_tail == TAIL_W'(1));

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      r_m_data   <= '0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_trig_cnt <= '0;
    end else begin
      r_m_valid <= w_gate;
      r_m_last  <= w_gate & w_last;
      if (S_AXIS_TVALID) r_m_data <= w_dly_out;
      if (w_last) r_trig_cnt <= r_trig_cnt + 32'd1;
    end
  end

  assign M_AXIS_TDATA  = r_m_data;
  assign M_AXIS_TVALID = r_m_valid;
  assign M_AXIS_TLAST  = r_m_last;
  assign O_EXEC_STATE  = r_state;
  assign O_TRIG_CNT    = r_trig_cnt;

`ifdef TRIG_TIMESTAMP_EN
  logic [47:0] r_ts_cnt, r_ts;
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      r_ts_cnt <= '0;
      r_ts     <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 48'd1;
      if (w_trig) r_ts <= r_ts_cnt;
    end
  end
  assign O_TRIG_TIMESTAMP = r_ts;
`else
  assign O_TRIG_TIMESTAMP = '0;
`endif

endmodule

// File: tb/tb_trigger_gate.sv
// Randomized bench for trigger_gate; frames are predicted from the beat log after each run.
module tb_trigger_gate;
  localparam int THR  = 410;
  localparam int PRE  = 2;
  localparam int POST = 4;
  localparam int MAXL = 64;
  localparam int CAP  = MAXL - PRE;
  localparam int MAXB = 1024;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [11:0]  I_BASELINE = '0;
  logic         I_CALC_COMPLETE = 1'b0;
  logic [127:0] S_AXIS_TDATA = '0;
  logic         S_AXIS_TVALID = 1'b0;
  logic [127:0] M_AXIS_TDATA;
  logic         M_AXIS_TVALID, M_AXIS_TLAST;
  logic [1:0]   O_EXEC_STATE;
  logic [31:0]  O_TRIG_CNT;
  logic [47:0]  O_TRIG_TIMESTAMP;

  trigger_gate dut (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .I_BASELINE(I_BASELINE),
    .I_CALC_COMPLETE(I_CALC_COMPLETE), .S_AXIS_TDATA(S_AXIS_TDATA),
    .S_AXIS_TVALID(S_AXIS_TVALID), .M_AXIS_TDATA(M_AXIS_TDATA),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST),
    .O_EXEC_STATE(O_EXEC_STATE), .O_TRIG_CNT(O_TRIG_CNT),
    .O_TRIG_TIMESTAMP(O_TRIG_TIMESTAMP)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Beat log of the current run and what the DUT showed one cycle after each beat.
  logic [127:0] b_data [MAXB];
  int           b_bl   [MAXB];
  bit           b_armed[MAXB];
  longint       b_cyc  [MAXB];
  logic         o_valid[MAXB];
  logic         o_last [MAXB];
  logic [127:0] o_data [MAXB];
  logic [1:0]   o_state[MAXB];
  logic [31:0]  o_cnt  [MAXB];
  logic [47:0]  o_ts   [MAXB];
  int           nb;
  bit           calc_seen;
  longint       tb_cyc;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit is_hit(input logic [127:0] d, input int bl);
    for (int i = 0; i < 8; i++)
      if (int'(d[16*i +: 12]) > bl + THR) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [127:0] rand_full();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] flat(input int val);
    logic [127:0] d;
    for (int i = 0; i < 8; i++) d[16*i +: 16] = {4'($urandom), 12'(val)};
    return d;
  endfunction

  function automatic logic [127:0] rand_beat(input int bl, input bit hit);
    logic [127:0] d;
    int lvl, lo;
    lvl = (bl + THR > 4095) ? 4095 : bl + THR;
    for (int i = 0; i < 8; i++) d[16*i +: 16] = {4'($urandom), 12'($urandom_range(lvl, 0))};
    lo = bl + THR + 1;
    if (hit && lo <= 4095) d[16*($urandom % 8) +: 12] = 12'($urandom_range(4095, lo));
    return d;
  endfunction

  // Entered and left at a falling edge; outputs sampled 1 time unit after the rising edge.
  task automatic cycle(input logic v, input logic [127:0] d, input int bl, input logic calc);
    if (nb >= MAXB) begin
      $display("FAIL beat_log: got %0d expected below %0d", nb, MAXB);
      $fatal(1);
    end
    S_AXIS_TVALID   = v;
    S_AXIS_TDATA    = d;
    I_BASELINE      = 12'(bl);
    I_CALC_COMPLETE = calc;
    if (v) begin
      b_data[nb] = d; b_bl[nb] = bl; b_armed[nb] = calc_seen; b_cyc[nb] = tb_cyc;
    end
    @(posedge clk);
    tb_cyc++;
    #1;
    if (v) begin
      o_valid[nb] = M_AXIS_TVALID; o_last[nb] = M_AXIS_TLAST; o_data[nb] = M_AXIS_TDATA;
      o_state[nb] = O_EXEC_STATE; o_cnt[nb] = O_TRIG_CNT; o_ts[nb] = O_TRIG_TIMESTAMP;
      nb++;
    end else begin
      chk("idle_tvalid", 128'(M_AXIS_TVALID), 128'(0));
    end
    if (calc) calc_seen = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; S_AXIS_TVALID = 1'b0; I_CALC_COMPLETE = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_state", 128'(O_EXEC_STATE), 128'(0));
    chk("rst_tvalid", 128'(M_AXIS_TVALID), 128'(0));
    chk("rst_tlast", 128'(M_AXIS_TLAST), 128'(0));
    chk("rst_tdata", M_AXIS_TDATA, 128'(0));
    chk("rst_cnt", 128'(O_TRIG_CNT), 128'(0));
    chk("rst_ts", 128'(O_TRIG_TIMESTAMP), 128'(0));
    rst_n = 1'b1; nb = 0; calc_seen = 1'b0; tb_cyc = 0;
  endtask

  // Frame rules applied to the beat log: window T..E, output valid T..E+PRE, last at E+PRE.
  task automatic compare_run();
    bit     e_valid[MAXB], e_last[MAXB], e_trig[MAXB];
    logic [1:0] e_state[MAXB];
    int     n, next_ok, t, e_end, post, cnt;
    logic [47:0] ts_cur;
    for (int i = 0; i < nb; i++) begin
      e_valid[i] = 0; e_last[i] = 0; e_trig[i] = 0; e_state[i] = 2'b01;
    end
    n = 0; next_ok = 0;
    while (n < nb) begin
      if (b_armed[n] && n >= next_ok && is_hit(b_data[n], b_bl[n])) begin
        t = n; post = 0; e_end = -1; e_trig[t] = 1;
        for (int e = t; e < nb; e++) begin
          if (e > t) post = is_hit(b_data[e], b_bl[e]) ? 0 : post + 1;
          e_valid[e] = 1;
          if (e - t + 1 >= CAP || (e > t && post >= POST)) begin
            e_end = e;
            break;
          end
          e_state[e] = (post == 0) ? 2'b11 : 2'b10;
        end
        if (e_end < 0) n = nb;
        else begin
          for (int e = e_end + 1; e <= e_end + PRE && e < nb; e++) e_valid[e] = 1;
          if (e_end + PRE < nb) e_last[e_end + PRE] = 1;
          next_ok = e_end + PRE + 1;
          n = e_end + 1;
        end
      end else n++;
    end
    cnt = 0; ts_cur = '0;
    for (int i = 0; i < nb; i++) begin
      if (e_last[i]) cnt++;
`ifdef TRIG_TIMESTAMP_EN
      if (e_trig[i]) ts_cur = 48'(b_cyc[i]);
`endif
      chk($sformatf("tvalid[%0d]", i), 128'(o_valid[i]), 128'(e_valid[i]));
      if (e_valid[i]) begin
        chk($sformatf("tdata[%0d]", i), o_data[i], (i >= PRE) ? b_data[i-PRE] : 128'(0));
        chk($sformatf("tlast[%0d]", i), 128'(o_last[i]), 128'(e_last[i]));
      end
      if (b_armed[i]) chk($sformatf("state[%0d]", i), 128'(o_state[i]), 128'(e_state[i]));
      chk($sformatf("trig_cnt[%0d]", i), 128'(o_cnt[i]), 128'(cnt));
      chk($sformatf("timestamp[%0d]", i), 128'(o_ts[i]), 128'(ts_cur));
    end
  endtask

  // Modes 0-5 follow the directed scenarios, 6-7 are random sparse / dense traffic.
  task automatic run_mode(input int mode);
    int len, bl, j, k, exp_cnt;
    bit v, hit;
    logic [127:0] d;
    do_reset();
    bl = (mode == 5) ? 3800 : 1000;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, rand_full(), bl, 1'b0);
      chk("init_state", 128'(O_EXEC_STATE), 128'(0));
    end
    cycle(1'b1, rand_full(), bl, 1'b1);
    chk("arm_state", 128'(O_EXEC_STATE), 128'(1));
    case (mode)
      0, 1, 2: len = 40;
      3, 4:    len = 220;
      5:       len = 30;
      6:       len = 400;
      default: len = 150;
    endcase
    j = 0; k = 0;
    while (j < len) begin
      case (mode)
        4:       v = (k % 3) != 2;
        6:       v = ($urandom % 4) != 0;
        7:       v = ($urandom % 5) != 0;
        default: v = 1'b1;
      endcase
      if (!v) cycle(1'b0, rand_full(), int'($urandom_range(4095, 0)), 1'b1);
      else begin
        case (mode)
          0, 1, 2: begin
            d = flat(1000);
            if (j == 10 || (mode == 2 && j == 13)) d[16*3 +: 12] = (mode == 1) ? 12'd1410 : 12'd1411;
          end
          3, 4: begin
            d = flat(1000);
            if (j >= 10 && j <= 200) d[16*5 +: 12] = 12'd1411;
          end
          5: d = flat(4095);
          6: begin
            bl  = int'($urandom_range(3700, 0));
            hit = ($urandom % 25) == 0;
            d   = rand_beat(bl, hit);
          end
          default: begin
            hit = ($urandom % 10) < 6;
            d   = rand_beat(bl, hit);
          end
        endcase
        cycle(1'b1, d, bl, 1'b1);
        j++;
      end
      k++;
    end
    if (mode <= 5) begin
      case (mode)
        0, 2:    exp_cnt = 1;
        3, 4:    exp_cnt = 3;
        default: exp_cnt = 0;
      endcase
      chk($sformatf("final_cnt_mode%0d", mode), 128'(O_TRIG_CNT), 128'(exp_cnt));
    end
    compare_run();
  endtask

  initial begin
    for (int m = 0; m < 8; m++) run_mode(m);
    run_mode(6);
    run_mode(7);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
